ahb_bram_ctrl: RTL and testbench

AHB-Lite slave front end for the Cortex-M0 program/data Block RAM. It sits directly upstream of the simple dual-port byte-enable BRAM. It converts AHB address and data phases into the RAM's write port (addra/dina/wea) and synchronous read port (addrb/doutb), decodes byte lanes and flags misaligned accesses. It also forwards write data so that a read issued back-to-back after a write to the same word returns the new value. All legal transfers complete with zero wait states.

---
 rtl/ahb_bram_ctrl.sv | 132 +++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite zero-wait-state slave bridging onto a simple dual-port byte-enable BRAM.
// Handles lane decode, misalignment errors and write-to-read forwarding.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [31:0]           BRAM_DINA,
  output logic [3:0]            BRAM_WEA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_DOUTB
);

  typedef enum logic [1:0] {
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } err_state_t;

  err_state_t state, state_nxt;

  logic                  accept;
  logic                  misaligned;
  logic                  legal_wr;
  logic                  legal_rd;
  logic                  fwd_hit;
  logic [3:0]            lane_mask;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_mask;
  logic                  rd_pend;
  logic                  fwd;
  logic [31:0]           fwd_data;
  logic [3:0]            fwd_mask;
  logic [31:0]           rd_merged;
  logic                  wr_active;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign word_addr = HADDR[ADDR_WIDTH+1:2];
  assign legal_wr  = accept & ~misaligned & HWRITE;
  assign legal_rd  = accept & ~misaligned & ~HWRITE;
  // The BRAM returns stale data when reading the word being written this cycle.
  assign fwd_hit   = legal_rd & wr_pend & (wr_addr == word_addr);

  always_comb begin
    lane_mask  = 4'b0000;
    misaligned = 1'b0;
    case (HSIZE)
      3'd0: lane_mask = 4'b0001 << HADDR[1:0];
      3'd1: begin
        lane_mask  = HADDR[1] ? 4'b1100 : 4'b0011;
        misaligned = HADDR[0];
      end
      3'd2: begin
        lane_mask  = 4'b1111;
        misaligned = |HADDR[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_OKAY;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_mask  <= 4'b0000;
      rd_pend  <= 1'b0;
      fwd      <= 1'b0;
      fwd_data <= 32'h0;
      fwd_mask <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (HREADY) begin
        wr_pend <= legal_wr;
        rd_pend <= legal_rd;
        fwd     <= fwd_hit;
        if (legal_wr) begin
          wr_addr <= word_addr;
          wr_mask <= lane_mask;
        end
        if (fwd_hit) begin
          fwd_data <= HWDATA;
          fwd_mask <= wr_mask;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OKAY: if (accept && misaligned) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = (accept && misaligned) ? ST_ERR1 : ST_OKAY;
      default: state_nxt = ST_OKAY;
    endcase
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_merged[8*b +: 8] = (fwd && fwd_mask[b]) ? fwd_data[8*b +: 8] : BRAM_DOUTB[8*b +: 8];
    end
  end

  // Outputs are gated by reset so they are clean even before the first clock edge.
  assign wr_active  = HRESETn & wr_pend;
  assign HREADYOUT  = ~HRESETn | (state != ST_ERR1);
  assign HRESP      = HRESETn & (state != ST_OKAY);
  assign HRDATA     = (HRESETn & rd_pend) ? rd_merged : 32'h0;
  assign BRAM_WEA   = wr_active ? wr_mask : 4'b0000;
  assign BRAM_DINA  = wr_active ? HWDATA : 32'h0;
  assign BRAM_ADDRA = wr_addr;
  assign BRAM_ADDRB = word_addr;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Self-checking bench for ahb_bram_ctrl: bus-level memory model plus directed vectors.
// A behavioural BRAM (read-old-data on collision) sits behind the DUT.
module tb_ahb_bram_ctrl;

  localparam int AW    = 14;
  localparam int WORDS = 1 << AW;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] BRAM_ADDRA;
  logic [31:0]   BRAM_DINA;
  logic [3:0]    BRAM_WEA;
  logic [AW-1:0] BRAM_ADDRB;
  logic [31:0]   BRAM_DOUTB;

  int test_count = 0;
  int fail_count = 0;

  logic [31:0] bram [WORDS];
  logic [31:0] gold [WORDS];

  logic          dp_valid = 1'b0;
  logic          dp_write = 1'b0;
  logic          dp_err   = 1'b0;
  logic [AW-1:0] dp_word  = '0;
  logic [3:0]    dp_mask  = 4'b0;
  int            err_phase = 0;

  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] IDLE = 2'b00;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .BRAM_ADDRA(BRAM_ADDRA), .BRAM_DINA(BRAM_DINA), .BRAM_WEA(BRAM_WEA),
    .BRAM_ADDRB(BRAM_ADDRB), .BRAM_DOUTB(BRAM_DOUTB)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [3:0] laneMask(input logic [2:0] size, input logic [1:0] a);
    if (size == 3'd0) return 4'(1 << a);
    if (size == 3'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic isMisaligned(input logic [2:0] size, input logic [1:0] a);
    return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a != 2'd0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic [2:0] size, input logic write, input logic ready,
                               input logic [31:0] wdata);
    @(posedge HCLK);
    #1;
    HSEL   = sel;
    HTRANS = trans;
    HADDR  = addr;
    HSIZE  = size;
    HWRITE = write;
    HREADY = ready;
    HWDATA = wdata;
  endtask

  // Behavioural BRAM: the read port sees the contents from before this edge's write.
  always @(posedge HCLK) begin
    logic [31:0] rd_word;
    logic [31:0] tmp;
    rd_word = bram[BRAM_ADDRB];
    tmp = bram[BRAM_ADDRA];
    for (int b = 0; b < 4; b++) if (BRAM_WEA[b]) tmp[8*b +: 8] = BRAM_DINA[8*b +: 8];
    bram[BRAM_ADDRA] = tmp;
    BRAM_DOUTB <= rd_word;
  end

  // Bus-level model: which transfer owns the data phase, and what memory the bus should see.
  always @(posedge HCLK) begin
    logic acc;
    logic bad;
    if (!HRESETn) begin
      dp_valid  = 1'b0;
      dp_err    = 1'b0;
      err_phase = 0;
    end else begin
      if (dp_valid && dp_write && !dp_err)
        for (int b = 0; b < 4; b++) if (dp_mask[b]) gold[dp_word][8*b +: 8] = HWDATA[8*b +: 8];
      acc = HSEL && HTRANS[1] && HREADY;
      bad = acc && isMisaligned(HSIZE, HADDR[1:0]);
      if (err_phase == 1) err_phase = 2;
      else err_phase = bad ? 1 : 0;
      if (HREADY) begin
        dp_valid = acc;
        dp_write = HWRITE;
        dp_err   = bad;
        dp_word  = HADDR[AW+1:2];
        dp_mask  = laneMask(HSIZE, HADDR[1:0]);
      end else begin
        dp_valid = 1'b0;
      end
    end
  end

  always @(negedge HCLK) begin
    logic wr_now;
    logic rd_now;
    wr_now = HRESETn && dp_valid && dp_write && !dp_err;
    rd_now = HRESETn && dp_valid && !dp_write && !dp_err;
    checkOutput("cyc_hreadyout", {31'b0, HREADYOUT}, {31'b0, !(HRESETn && err_phase == 1)});
    checkOutput("cyc_hresp", {31'b0, HRESP}, {31'b0, HRESETn && err_phase != 0});
    checkOutput("cyc_wea", {28'b0, BRAM_WEA}, {28'b0, wr_now ? dp_mask : 4'b0});
    checkOutput("cyc_dina", BRAM_DINA, wr_now ? HWDATA : 32'h0);
    checkOutput("cyc_hrdata", HRDATA, rd_now ? gold[dp_word] : 32'h0);
    if (wr_now) checkOutput("cyc_addra", {18'b0, BRAM_ADDRA}, {18'b0, dp_word});
    if (HRESETn && HSEL && HTRANS[1] && HREADY && !HWRITE)
      checkOutput("cyc_addrb", {18'b0, BRAM_ADDRB}, {18'b0, HADDR[AW+1:2]});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      bram[i] = 32'hC0DE_0000 | i;
      gold[i] = 32'hC0DE_0000 | i;
    end
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = IDLE; HADDR = '0; HSIZE = 3'd0; HWRITE = 1'b0;
    HREADY = 1'b1; HWDATA = '0;

    // Reset with an active write presented
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, NS, 32'h50, 3'd2, 1, 1, 32'hCAFEF00D);
      @(negedge HCLK);
      checkOutput("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
      checkOutput("rst_hresp", {31'b0, HRESP}, 32'h0);
      checkOutput("rst_wea", {28'b0, BRAM_WEA}, 32'h0);
    end
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'hCAFEF00D);
    HRESETn = 1'b1;
    @(negedge HCLK);
    checkOutput("post_rst_wea", {28'b0, BRAM_WEA}, 32'h0);
    checkOutput("post_rst_hrdata", HRDATA, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);

    // Word write, idle, read back
    applyStimulus(1, NS, 32'h10, 3'd2, 1, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'hDEADBEEF);
    @(negedge HCLK);
    checkOutput("ww_wea", {28'b0, BRAM_WEA}, 32'hF);
    checkOutput("ww_addra", {18'b0, BRAM_ADDRA}, 32'h4);
    applyStimulus(1, NS, 32'h10, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("ww_read", HRDATA, 32'hDEADBEEF);

    // Byte then halfword write, word read
    applyStimulus(1, NS, 32'h13, 3'd0, 1, 1, 32'h0);
    applyStimulus(1, NS, 32'h10, 3'd1, 1, 1, 32'hAA000000);
    @(negedge HCLK);
    checkOutput("bw_wea", {28'b0, BRAM_WEA}, 32'h8);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h00005555);
    @(negedge HCLK);
    checkOutput("hw_wea", {28'b0, BRAM_WEA}, 32'h3);
    applyStimulus(1, NS, 32'h10, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("bh_read", HRDATA, 32'hAAAD5555);

    // Forwarding: write immediately followed by read of the same word
    applyStimulus(1, NS, 32'h20, 3'd2, 1, 1, 32'h0);
    applyStimulus(1, NS, 32'h20, 3'd2, 0, 1, 32'h12345678);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("fwd_word", HRDATA, 32'h12345678);
    applyStimulus(1, NS, 32'h21, 3'd0, 1, 1, 32'h0);
    applyStimulus(1, NS, 32'h20, 3'd2, 0, 1, 32'h0000FF00);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("fwd_byte", HRDATA, 32'h1234FF78);
    applyStimulus(1, NS, 32'h20, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("fwd_ram", HRDATA, 32'h1234FF78);

    // Misaligned halfword write, then a read accepted during ERR2
    applyStimulus(1, NS, 32'h30, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("pre_err_read", HRDATA, 32'hC0DE000C);
    applyStimulus(1, NS, 32'h31, 3'd1, 1, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 0, 32'hFFFFFFFF);
    @(negedge HCLK);
    checkOutput("err1_ready", {31'b0, HREADYOUT}, 32'h0);
    checkOutput("err1_resp", {31'b0, HRESP}, 32'h1);
    checkOutput("err1_wea", {28'b0, BRAM_WEA}, 32'h0);
    applyStimulus(1, NS, 32'h40, 3'd2, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("err2_ready", {31'b0, HREADYOUT}, 32'h1);
    checkOutput("err2_resp", {31'b0, HRESP}, 32'h1);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("err2_read_resp", {31'b0, HRESP}, 32'h0);
    checkOutput("err2_read_data", HRDATA, 32'hC0DE0010);
    applyStimulus(1, NS, 32'h30, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("err_ram_intact", HRDATA, 32'hC0DE000C);

    // Misaligned word read returns zero data
    applyStimulus(1, NS, 32'h42, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 0, 32'h0);
    @(negedge HCLK);
    checkOutput("mis_rd_data", HRDATA, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);

    // Illegal size, then back-to-back errors via ERR2
    applyStimulus(1, NS, 32'h50, 3'd3, 1, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 0, 32'hFFFFFFFF);
    applyStimulus(1, NS, 32'h33, 3'd1, 1, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 0, 32'hFFFFFFFF);
    @(negedge HCLK);
    checkOutput("err_again_ready", {31'b0, HREADYOUT}, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    applyStimulus(1, NS, 32'h50, 3'd2, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("size3_ram_intact", HRDATA, 32'hC0DE0014);

    // HREADY low and HSEL low leave the RAM alone
    applyStimulus(1, NS, 32'h60, 3'd2, 1, 0, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h99999999);
    @(negedge HCLK);
    checkOutput("hready_low_wea", {28'b0, BRAM_WEA}, 32'h0);
    applyStimulus(0, NS, 32'h60, 3'd2, 1, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h88888888);
    @(negedge HCLK);
    checkOutput("hsel_low_wea", {28'b0, BRAM_WEA}, 32'h0);

    // Upper address bits ignored
    applyStimulus(1, NS, 32'h0001_0014, 3'd2, 1, 1, 32'h0);
    applyStimulus(1, NS, 32'h14, 3'd2, 0, 1, 32'h11223344);
    @(negedge HCLK);
    checkOutput("wrap_addra", {18'b0, BRAM_ADDRA}, 32'h5);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("wrap_read", HRDATA, 32'h11223344);

    // Back-to-back writes then back-to-back reads
    applyStimulus(1, NS, 32'h60, 3'd2, 1, 1, 32'h0);
    applyStimulus(1, NS, 32'h64, 3'd2, 1, 1, 32'hA1A1A1A1);
    applyStimulus(1, NS, 32'h60, 3'd2, 0, 1, 32'hB2B2B2B2);
    applyStimulus(1, NS, 32'h64, 3'd2, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("b2b_read0", HRDATA, 32'hA1A1A1A1);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("b2b_read1", HRDATA, 32'hB2B2B2B2);

    // Read, byte write, read of the same word
    applyStimulus(1, NS, 32'h70, 3'd2, 0, 1, 32'h0);
    applyStimulus(1, NS, 32'h70, 3'd0, 1, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("rwr_read0", HRDATA, 32'hC0DE001C);
    applyStimulus(1, NS, 32'h70, 3'd2, 0, 1, 32'h000000EE);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    checkOutput("rwr_read1", HRDATA, 32'hC0DE00EE);

    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    applyStimulus(0, IDLE, 32'h0, 3'd0, 0, 1, 32'h0);
    @(negedge HCLK);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
